// File: rtl/timer_sched_if.sv
// wb_bus_t: single-beat Wishbone link between timer_sched (master) and the timer slave.
interface wb_bus_t;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;
  logic [3:0]  sel;
  modport master(output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, sel,
                 input wb_ack, wb_err, wb_dat_sm);
  modport slave(input wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, sel,
                output wb_ack, wb_err, wb_dat_sm);
endinterface

// File: rtl/timer_sched.sv
// timer_sched: multiplexes N_CH absolute deadlines onto one timer CMP register.
module timer_sched #(
  parameter int          N_CH       = 4,
  parameter logic [31:0] TIMER_BASE = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    arm_valid_i,
  output logic                    arm_ready_o,
  input  logic [$clog2(N_CH)-1:0] arm_ch_i,
  input  logic [31:0]             arm_deadline_i,
  input  logic [N_CH-1:0]         cancel_i,
  input  logic                    cmp_irq_i,
  output logic [N_CH-1:0]         expired_o,
  output logic [N_CH-1:0]         active_o,
  output logic                    err_o,
  wb_bus_t.master                 wb_bus
);
  typedef enum logic [2:0] {WR_CMP, SETTLE, WAIT, RD_TMR, EXPIRE} state_t;
  state_t          state, nxt;
  logic [31:0]     deadline [N_CH];
  logic [N_CH-1:0] active, exp_mask, arm_hot;
  logic [31:0]     target, now, dat;
  logic            dirty, cyc, we, done, arm_acc, issue_wr, issue_rd;
  assign done        = wb_bus.wb_ack || wb_bus.wb_err;
  assign err_o       = cyc && wb_bus.wb_err;
  assign arm_ready_o = state != EXPIRE;
  assign arm_acc     = arm_valid_i && arm_ready_o;
  assign arm_hot     = arm_acc ? N_CH'(1) << arm_ch_i : '0;
  assign expired_o   = state == EXPIRE ? exp_mask : '0;
  assign active_o    = active;
  always_comb begin
    exp_mask = '0;
    for (int i = 0; i < N_CH; i++) exp_mask[i] = active[i] && deadline[i] <= now;
  end
  // Channels retiring this cycle are excluded so the rewrite after EXPIRE is already correct
  always_comb begin
    target = '1;
    for (int i = 0; i < N_CH; i++)
      if (active[i] && !expired_o[i] && deadline[i] < target) target = deadline[i];
  end
  always_comb begin
    nxt = state;
    case (state)
      WR_CMP:  nxt = cyc && done ? SETTLE : WR_CMP;
      SETTLE:  nxt = WAIT;
      WAIT:    nxt = dirty ? WR_CMP : cmp_irq_i && |active ? RD_TMR : WAIT;
      RD_TMR:  nxt = !(cyc && done) ? RD_TMR : wb_bus.wb_ack ? EXPIRE : WAIT;
      default: nxt = WR_CMP;
    endcase
  end
  // Transfers launch on the edge that enters the state; the post-reset write launches from WR_CMP idle
  assign issue_wr = nxt == WR_CMP && !(state == WR_CMP && cyc);
  assign issue_rd = nxt == RD_TMR && state != RD_TMR;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state  <= WR_CMP;
      cyc    <= 1'b0;
      we     <= 1'b0;
      dat    <= '1;
      now    <= '0;
      active <= '0;
      dirty  <= 1'b0;
      for (int i = 0; i < N_CH; i++) deadline[i] <= '0;
    end else begin
      state  <= nxt;
      cyc    <= issue_wr || issue_rd || (cyc && !done);
      if (issue_wr || issue_rd) we <= issue_wr;
      if (issue_wr) dat <= target;
      if (state == RD_TMR && cyc && wb_bus.wb_ack) now <= wb_bus.wb_dat_sm;
      active <= (active & ~cancel_i & ~expired_o) | arm_hot;
      dirty  <= (dirty && !issue_wr) || arm_acc || |(cancel_i & active & ~arm_hot);
      if (arm_acc) deadline[arm_ch_i] <= arm_deadline_i;
    end
  end
  assign wb_bus.wb_cyc    = cyc;
  assign wb_bus.wb_stb    = cyc;
  assign wb_bus.wb_we     = we;
  assign wb_bus.wb_adr    = TIMER_BASE + (we ? 32'h8 : 32'h4);
  assign wb_bus.wb_dat_ms = dat;
  assign wb_bus.sel       = 4'hF;
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: scoreboard bench with a behavioural channel model and a Wishbone slave stub.
module tb_timer_sched;
  localparam int N = 4;
  logic clk = 0, rst_i = 1;
  always #5 clk = ~clk;
  logic          arm_valid_i = 0, cmp_irq_i = 0, err_o, arm_ready_o;
  logic [1:0]    arm_ch_i = 0;
  logic [31:0]   arm_deadline_i = 0;
  logic [N-1:0]  cancel_i = 0, expired_o, active_o;
  logic          ack_en = 1, err_mode = 0;
  logic [31:0]   timer_val = 0;
  wb_bus_t bus();
  assign bus.wb_ack    = bus.wb_cyc & bus.wb_stb & ack_en & ~err_mode;
  assign bus.wb_err    = bus.wb_cyc & bus.wb_stb & err_mode;
  assign bus.wb_dat_sm = timer_val;
  timer_sched #(.N_CH(N), .TIMER_BASE(32'h0)) dut (
    .clk(clk), .rst_i(rst_i), .arm_valid_i(arm_valid_i), .arm_ready_o(arm_ready_o),
    .arm_ch_i(arm_ch_i), .arm_deadline_i(arm_deadline_i), .cancel_i(cancel_i),
    .cmp_irq_i(cmp_irq_i), .expired_o(expired_o), .active_o(active_o), .err_o(err_o),
    .wb_bus(bus));
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} xact_t;
  xact_t        bq[$];
  logic [N-1:0] xq[$];
  xact_t        e;
  logic [N-1:0] ex;
  logic [31:0]  m_dl [N];
  logic [N-1:0] m_act = 0;
  int vectors = 0, fails = 0, err_seen = 0, err_exp = 0, reads_seen = 0;
  task automatic check(string n, logic [31:0] a, logic [31:0] x);
    vectors++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  function automatic logic [31:0] m_min();
    logic [31:0] b = '1;
    for (int i = 0; i < N; i++) if (m_act[i] && m_dl[i] < b) b = m_dl[i];
    return b;
  endfunction
  task automatic push_wr(logic [31:0] v);
    bq.push_back('{1'b1, 32'h8, v});
  endtask
  always @(negedge clk) if (!rst_i) begin
    if (bus.wb_cyc && bus.wb_stb && (bus.wb_ack || bus.wb_err)) begin
      if (bq.size() == 0) begin
        vectors++; fails++;
        $display("FAIL bus_unexpected: got we %b adr %h dat %h expected no transfer", bus.wb_we, bus.wb_adr, bus.wb_dat_ms);
      end else begin
        e = bq.pop_front();
        check("bus_we", bus.wb_we, e.we);
        check("bus_adr", bus.wb_adr, e.adr);
        if (e.we) begin
          check("cmp_data", bus.wb_dat_ms, e.dat);
          check("bus_sel", bus.sel, 4'hF);
        end else reads_seen++;
      end
    end
    if (expired_o != 0) begin
      if (xq.size() == 0) begin
        vectors++; fails++;
        $display("FAIL expired_unexpected: got %b expected 0", expired_o);
      end else begin
        ex = xq.pop_front();
        check("expired", expired_o, ex);
      end
    end
    if (err_o) err_seen++;
  end
  task automatic wait_idle();
    for (int k = 0; k < 300 && (bq.size() != 0 || xq.size() != 0); k++) @(negedge clk);
    if (bq.size() != 0 || xq.size() != 0) begin
      vectors++; fails++;
      $display("FAIL idle_timeout: got %0d pending expected 0", bq.size() + xq.size());
      bq.delete(); xq.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic arm(int ch, logic [31:0] d, logic [N-1:0] canc = 0);
    @(negedge clk);
    check("arm_ready", arm_ready_o, 1);
    arm_valid_i = 1; arm_ch_i = 2'(ch); arm_deadline_i = d; cancel_i = canc;
    @(negedge clk);
    arm_valid_i = 0; cancel_i = 0;
    m_act &= ~canc; m_dl[ch] = d; m_act[ch] = 1;
    push_wr(m_min());
  endtask
  task automatic cancel(logic [N-1:0] mask);
    logic hit = |(m_act & mask);
    @(negedge clk); cancel_i = mask;
    @(negedge clk); cancel_i = 0;
    m_act &= ~mask;
    if (hit) push_wr(m_min());
  endtask
  task automatic irq(logic [31:0] t);
    logic [N-1:0] mask = 0;
    int n0 = reads_seen;
    for (int i = 0; i < N; i++) mask[i] = m_act[i] && m_dl[i] <= t;
    timer_val = t;
    bq.push_back('{1'b0, 32'h4, 32'h0});
    if (mask != 0) xq.push_back(mask);
    m_act &= ~mask;
    push_wr(m_min());
    @(negedge clk); cmp_irq_i = 1;
    for (int k = 0; k < 50 && reads_seen == n0; k++) begin @(negedge clk); #1; end
    cmp_irq_i = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < N; i++) m_dl[i] = 0;
    push_wr(32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    check("rst_active", active_o, 0);
    check("rst_expired", expired_o, 0);
    check("rst_ready", arm_ready_o, 1);
    check("rst_cyc", bus.wb_cyc, 0);
    check("rst_err", err_o, 0);
    rst_i = 0;
    wait_idle();
    arm(1, 100); wait_idle();
    irq(101); wait_idle();
    @(negedge clk); arm_valid_i = 1; arm_ch_i = 0; arm_deadline_i = 300;
    @(negedge clk); arm_ch_i = 2; arm_deadline_i = 200;
    @(negedge clk); arm_valid_i = 0;
    m_dl[0] = 300; m_act[0] = 1; push_wr(m_min());
    m_dl[2] = 200; m_act[2] = 1; push_wr(m_min());
    wait_idle();
    irq(201); wait_idle();
    check("ch0_kept", active_o, 4'b0001);
    arm(1, 50); wait_idle();
    arm(3, 50); wait_idle();
    irq(60); wait_idle();
    arm(0, 400); wait_idle();
    arm(0, 500, 4'b0001); wait_idle();
    check("arm_beats_cancel", active_o, 4'b0001);
    cancel(4'b0001); wait_idle();
    err_mode = 1;
    arm(2, 700); err_exp++;
    wait_idle();
    err_mode = 0;
    check("err_pulses", err_seen, err_exp);
    arm(1, 800); wait_idle();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: arm($urandom_range(0, N - 1), $urandom_range(0, 1000));
        1: cancel(4'(1 << $urandom_range(0, N - 1)));
        default: if (m_act != 0) irq($urandom_range(0, 1100));
      endcase
      wait_idle();
      check("active_model", active_o, m_act);
    end
    if (m_act == 0) begin arm(0, 900); wait_idle(); end
    ack_en = 0;
    @(negedge clk); cmp_irq_i = 1;
    repeat (3) @(negedge clk);
    check("held_rd_cyc", bus.wb_cyc, 1);
    check("held_rd_we", bus.wb_we, 0);
    check("held_rd_adr", bus.wb_adr, 32'h4);
    #2 rst_i = 1;
    #1 check("async_cyc_drop", bus.wb_cyc, 0);
    check("async_stb_drop", bus.wb_stb, 0);
    m_act = 0;
    push_wr(32'hFFFF_FFFF);
    cmp_irq_i = 0; ack_en = 1;
    @(negedge clk); rst_i = 0;
    wait_idle();
    check("post_rst_active", active_o, 0);
    check("err_total", err_seen, err_exp);
    check("bus_queue_empty", bq.size(), 0);
    check("exp_queue_empty", xq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
